// File: rtl/rf_write_arbiter_pkg.sv
// Shared widths and requester ids for the register-file write-port arbiter.
package rf_write_arbiter_pkg;

  localparam int N_REG_ADDR = 5;
  localparam int N_REG      = 32;
  localparam int N_DATA     = 32;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_PIPE = 2'd1,
    REQ_LSU  = 2'd2,
    REQ_DBG  = 2'd3
  } req_id_t;

endpackage

// File: rtl/rf_write_arbiter_scoreboard.sv
// Busy bitmap of registers with outstanding lsu writes; updates next edge, no backpressure.
// Clear applies before set so an issue to the same register wins; x0 never marked busy.
module rf_write_arbiter_scoreboard #(
  parameter int N_REG_ADDR = 5,
  parameter int N_REG      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_en,
  input  logic [N_REG_ADDR-1:0] clr_addr,
  input  logic                  set_en,
  input  logic [N_REG_ADDR-1:0] set_addr,
  output logic [N_REG-1:0]      busy
);

  logic [N_REG-1:0] busy_nxt;

  always_comb begin
    busy_nxt = busy;
    for (int i = 1; i < N_REG; i++) begin
      if (clr_en && clr_addr == N_REG_ADDR'(i)) busy_nxt[i] = 1'b0;
      if (set_en && set_addr == N_REG_ADDR'(i)) busy_nxt[i] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates pipe/lsu/dbg onto RF write port 3 combinationally (write lands same edge).
// Pipe has no ready: it is stalled only when a long-refused lsu write is forced through.
module rf_write_arbiter #(
  parameter int N_REG_ADDR = rf_write_arbiter_pkg::N_REG_ADDR,
  parameter int N_REG      = rf_write_arbiter_pkg::N_REG,
  parameter int N_DATA     = rf_write_arbiter_pkg::N_DATA,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_valid,
  input  logic [N_REG_ADDR-1:0] pipe_addr,
  input  logic [N_DATA-1:0]     pipe_data,
  output logic                  pipe_stall,
  input  logic                  lsu_issue_valid,
  input  logic [N_REG_ADDR-1:0] lsu_issue_addr,
  input  logic                  lsu_valid,
  input  logic [N_REG_ADDR-1:0] lsu_addr,
  input  logic [N_DATA-1:0]     lsu_data,
  output logic                  lsu_ready,
  input  logic                  dbg_valid,
  input  logic [N_REG_ADDR-1:0] dbg_addr,
  input  logic [N_DATA-1:0]     dbg_data,
  output logic                  dbg_ready,
  output logic                  rf_we,
  output logic [N_REG_ADDR-1:0] rf_addr,
  output logic [N_DATA-1:0]     rf_data,
  output logic [N_REG-1:0]      busy
);

  import rf_write_arbiter_pkg::*;

  localparam int                CNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt;
  logic             force_lsu;
  req_id_t          grant;

  // Outputs are gated by rst so they drop the instant reset asserts.
  always_comb begin
    force_lsu = !rst && lsu_valid && (wait_cnt == CNT_MAX);
    grant     = REQ_NONE;
    if (rst)             grant = REQ_NONE;
    else if (force_lsu)  grant = REQ_LSU;
    else if (pipe_valid) grant = REQ_PIPE;
    else if (lsu_valid)  grant = REQ_LSU;
    else if (dbg_valid)  grant = REQ_DBG;
  end

  always_comb begin
    rf_addr = '0;
    rf_data = '0;
    case (grant)
      REQ_PIPE: begin rf_addr = pipe_addr; rf_data = pipe_data; end
      REQ_LSU:  begin rf_addr = lsu_addr;  rf_data = lsu_data;  end
      REQ_DBG:  begin rf_addr = dbg_addr;  rf_data = dbg_data;  end
      default:  ;
    endcase
  end

  assign pipe_stall = force_lsu && pipe_valid;
  assign lsu_ready  = (grant == REQ_LSU);
  assign dbg_ready  = (grant == REQ_DBG);
  assign rf_we      = (grant != REQ_NONE) && (rf_addr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  wait_cnt <= '0;
    else if (lsu_ready)                       wait_cnt <= '0;
    else if (lsu_valid && wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + 1'b1;
  end

  rf_write_arbiter_scoreboard #(
    .N_REG_ADDR (N_REG_ADDR),
    .N_REG      (N_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .clr_en   (lsu_ready),
    .clr_addr (lsu_addr),
    .set_en   (lsu_issue_valid),
    .set_addr (lsu_issue_addr),
    .busy     (busy)
  );

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with a per-cycle behavioural model check.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        pipe_stall;
  logic        lsu_issue_valid;
  logic [4:0]  lsu_issue_addr;
  logic        lsu_valid;
  logic [4:0]  lsu_addr;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        dbg_valid;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        dbg_ready;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [31:0] busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rf_write_arbiter #(.N_REG_ADDR(5), .N_REG(32), .N_DATA(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_addr(pipe_addr), .pipe_data(pipe_data), .pipe_stall(pipe_stall),
    .lsu_issue_valid(lsu_issue_valid), .lsu_issue_addr(lsu_issue_addr),
    .lsu_valid(lsu_valid), .lsu_addr(lsu_addr), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .dbg_valid(dbg_valid), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_ready(dbg_ready),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data), .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: starvation count as a plain integer, outstanding loads as a set of register numbers.
  int m_wait;
  bit m_out[32];

  function automatic int who_wins();
    if (lsu_valid && m_wait >= 4) return 2;
    if (pipe_valid)               return 1;
    if (lsu_valid)                return 2;
    if (dbg_valid)                return 3;
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_wait = 0;
      foreach (m_out[i]) m_out[i] = 1'b0;
    end else begin
      int g;
      g = who_wins();
      if (g == 2) begin
        m_wait = 0;
        m_out[lsu_addr] = 1'b0;
      end else if (lsu_valid) begin
        m_wait = (m_wait < 4) ? m_wait + 1 : 4;
      end
      if (lsu_issue_valid && lsu_issue_addr != 0) m_out[lsu_issue_addr] = 1'b1;
    end
  end

  always @(negedge clk) begin
    int          g;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic [31:0] eb;
    g  = rst ? 0 : who_wins();
    ea = (g == 1) ? pipe_addr : (g == 2) ? lsu_addr : (g == 3) ? dbg_addr : 5'd0;
    ed = (g == 1) ? pipe_data : (g == 2) ? lsu_data : (g == 3) ? dbg_data : 32'd0;
    eb = '0;
    for (int i = 0; i < 32; i++) eb[i] = m_out[i];
    chk("m_stall", 64'(pipe_stall), 64'(g == 2 && pipe_valid && m_wait >= 4 && !rst));
    chk("m_lsu_ready", 64'(lsu_ready), 64'(g == 2));
    chk("m_dbg_ready", 64'(dbg_ready), 64'(g == 3));
    chk("m_rf_we", 64'(rf_we), 64'(g != 0 && ea != 0));
    chk("m_rf_addr", 64'(rf_addr), 64'(ea));
    chk("m_rf_data", 64'(rf_data), 64'(ed));
    chk("m_busy", 64'(busy), 64'(eb));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen;
    rst = 1'b1;
    pipe_valid = 0; pipe_addr = 0; pipe_data = 0;
    lsu_issue_valid = 0; lsu_issue_addr = 0;
    lsu_valid = 0; lsu_addr = 0; lsu_data = 0;
    dbg_valid = 0; dbg_addr = 0; dbg_data = 0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rf_we", 64'(rf_we), 64'd0);
    repeat (2) step();
    rst = 1'b0;

    // Pipe-only write lands the same cycle.
    pipe_valid = 1; pipe_addr = 5; pipe_data = 32'hDEADBEEF;
    #1;
    chk("pipe_we", 64'(rf_we), 64'd1);
    chk("pipe_addr", 64'(rf_addr), 64'd5);
    chk("pipe_data", 64'(rf_data), 64'hDEADBEEF);
    chk("pipe_stall", 64'(pipe_stall), 64'd0);
    step();
    pipe_valid = 0;

    // Scoreboard set, then clear by completion.
    lsu_issue_valid = 1; lsu_issue_addr = 9;
    step();
    lsu_issue_valid = 0;
    chk("sb_set9", 64'(busy[9]), 64'd1);
    lsu_valid = 1; lsu_addr = 9; lsu_data = 32'h11;
    #1;
    chk("sb_lsu_ready", 64'(lsu_ready), 64'd1);
    step();
    lsu_valid = 0;
    chk("sb_clr9", 64'(busy[9]), 64'd0);

    // Same-cycle completion and re-issue of x9: set wins.
    lsu_issue_valid = 1; lsu_issue_addr = 9;
    step();
    lsu_valid = 1; lsu_addr = 9; lsu_data = 32'h22;
    step();
    lsu_issue_valid = 0; lsu_valid = 0;
    chk("sb_setwins", 64'(busy[9]), 64'd1);
    lsu_valid = 1; lsu_addr = 9; lsu_data = 32'h23;
    step();
    lsu_valid = 0;
    chk("sb_clr9b", 64'(busy[9]), 64'd0);

    // x0: handshake completes, no write, never busy.
    lsu_issue_valid = 1; lsu_issue_addr = 0;
    lsu_valid = 1; lsu_addr = 0; lsu_data = 32'h55;
    #1;
    chk("x0_ready", 64'(lsu_ready), 64'd1);
    chk("x0_we", 64'(rf_we), 64'd0);
    step();
    lsu_issue_valid = 0; lsu_valid = 0;
    chk("x0_busy", 64'(busy[0]), 64'd0);

    // Starvation: four refusals, then lsu is forced and pipe stalls.
    pipe_valid = 1; pipe_addr = 2; pipe_data = 32'hA;
    lsu_valid = 1; lsu_addr = 7; lsu_data = 32'h77;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("starve_refused", 64'(lsu_ready), 64'd0);
      chk("starve_nostall", 64'(pipe_stall), 64'd0);
      step();
    end
    #1;
    chk("force_stall", 64'(pipe_stall), 64'd1);
    chk("force_ready", 64'(lsu_ready), 64'd1);
    chk("force_addr", 64'(rf_addr), 64'd7);
    chk("force_data", 64'(rf_data), 64'h77);
    step();
    lsu_addr = 8; lsu_data = 32'h88;
    #1;
    chk("cnt_cleared", 64'(lsu_ready), 64'd0);
    step();
    pipe_valid = 0;
    // x8 lsu now takes the idle port.
    step();
    lsu_valid = 0;

    // Debug waits behind pipe and lsu, then takes the first idle cycle.
    pipe_valid = 1; pipe_addr = 1; pipe_data = 32'h10;
    lsu_valid = 1; lsu_addr = 4; lsu_data = 32'h44;
    dbg_valid = 1; dbg_addr = 3; dbg_data = 32'h33;
    #1;
    chk("dbg_blocked_pipe", 64'(dbg_ready), 64'd0);
    step();
    pipe_valid = 0;
    #1;
    chk("dbg_blocked_lsu", 64'(dbg_ready), 64'd0);
    chk("dbg_lsu_first", 64'(lsu_ready), 64'd1);
    step();
    lsu_valid = 0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      #1;
      if (dbg_ready) seen = 1;
      else step();
    end
    chk("dbg_granted", 64'(seen), 64'd1);
    chk("dbg_we", 64'(rf_we), 64'd1);
    chk("dbg_addr", 64'(rf_addr), 64'd3);
    chk("dbg_data", 64'(rf_data), 64'h33);
    step();
    dbg_valid = 0;

    // Asynchronous reset in the middle of a cycle with traffic pending.
    lsu_issue_valid = 1; lsu_issue_addr = 12;
    step();
    lsu_issue_addr = 13;
    pipe_valid = 1; pipe_addr = 6; pipe_data = 32'h66;
    lsu_valid = 1; lsu_addr = 12; lsu_data = 32'hC;
    dbg_valid = 1; dbg_addr = 2; dbg_data = 32'h2;
    #1;
    chk("pre_rst_busy12", 64'(busy[12]), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_we", 64'(rf_we), 64'd0);
    chk("arst_lsu_ready", 64'(lsu_ready), 64'd0);
    chk("arst_dbg_ready", 64'(dbg_ready), 64'd0);
    chk("arst_stall", 64'(pipe_stall), 64'd0);
    chk("arst_addr", 64'(rf_addr), 64'd0);
    step();
    lsu_issue_valid = 0; pipe_valid = 0; dbg_valid = 0;
    step();
    rst = 1'b0;
    // The held lsu request is re-presented and accepted after release.
    #1;
    chk("post_rst_lsu", 64'(lsu_ready), 64'd1);
    step();
    lsu_valid = 0;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
